// File: rtl/adder_pkg.sv
// Shared definitions for the adder operand recovery checker.
// Contents:
//   state_t      - controller states (ST_IDLE, ST_SHIFT, ST_DONE)
//   ADDER_W      - default operand width
//   full_sub_bit - one-bit subtract with borrow, returns {borrow_out, diff}
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int ADDER_W = 2;

  // Computes sum_i - a_i - brw for one bit position.
  // Bit 1 of the result is the borrow out, bit 0 is the difference bit.
  function automatic logic [1:0] full_sub_bit(input logic sum_i,
                                              input logic a_i,
                                              input logic brw);
    logic d;
    logic brw_out;
    d       = sum_i ^ a_i ^ brw;
    brw_out = (~sum_i & (a_i | brw)) | (a_i & brw);
    return {brw_out, d};
  endfunction

endpackage

// File: rtl/adder_operand_recover_serial_sub_cell.sv
// One-bit serial subtractor with a registered borrow.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - seed the borrow flop with load_brw (start of a job)
//   load_brw  - initial borrow value (the adder carry-in)
//   en        - consume one bit this cycle and advance the borrow
//   sum_bit   - current bit of the adder result
//   a_bit     - current bit of the known operand
//   diff_bit  - difference bit for the current position
//   brw_next  - borrow produced by the current position
module serial_sub_cell
  import adder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_brw,
  input  logic en,
  input  logic sum_bit,
  input  logic a_bit,
  output logic diff_bit,
  output logic brw_next
);

  logic brw;

  assign {brw_next, diff_bit} = full_sub_bit(sum_bit, a_bit, brw);

  // Load takes precedence so a new job always starts from the carry-in,
  // whatever the previous job left behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      brw <= 1'b0;
    end else if (load) begin
      brw <= load_brw;
    end else if (en) begin
      brw <= brw_next;
    end
  end

endmodule

// File: rtl/adder_operand_recover.sv
// Recovers operand b of a ripple adder from its result {cout, s}, the
// known operand a and the carry-in, using an LSB-first serial borrow chain.
// Flags results that no W-bit b can produce.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_valid   - upstream has a job
//   in_ready   - block can accept a job (IDLE only)
//   in_sum     - adder result {cout, s[W-1:0]}
//   in_a       - known operand a
//   in_cin     - adder carry-in
//   out_valid  - result available (DONE)
//   out_ready  - downstream accepts the result
//   out_b      - recovered operand b (low W bits of the difference)
//   out_err    - difference was negative or did not fit in W bits
module adder_operand_recover
  import adder_pkg::*;
#(
  parameter int W = ADDER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_sum,
  input  logic [W-1:0] in_a,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_b,
  output logic         out_err
);

  // Counter must reach W without wrapping, so it needs ceil(log2(W+1)) bits.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  state_t state;
  state_t state_next;

  logic [CW-1:0] cnt;
  logic [W:0]    sum_sh;
  logic [W:0]    a_sh;
  logic [W-1:0]  res_sh;
  logic [W:0]    res_next;
  logic          accept;
  logic          shifting;
  logic          last_bit;
  logic          diff_bit;
  logic          brw_next;

  assign accept   = in_valid & in_ready;
  assign shifting = (state == ST_SHIFT);
  assign last_bit = shifting && (cnt == LAST);

  // Difference bits enter from the MSB side so that after W shifts the
  // register holds d[W-1:0] in place; bit W only feeds the error flag.
  assign res_next = {diff_bit, res_sh};

  serial_sub_cell u_cell (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_brw (in_cin),
    .en       (shifting),
    .sum_bit  (sum_sh[0]),
    .a_bit    (a_sh[0]),
    .diff_bit (diff_bit),
    .brw_next (brw_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. in_ready is gated by rst so nothing
  // upstream sees the block as ready while it is being reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, bit-serial shifting and result registers.
  // a gets a zero on top so position W subtracts only the pending borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sum_sh  <= '0;
      a_sh    <= '0;
      res_sh  <= '0;
      out_b   <= '0;
      out_err <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      sum_sh  <= in_sum;
      a_sh    <= {1'b0, in_a};
      res_sh  <= '0;
    end else if (shifting) begin
      sum_sh <= sum_sh >> 1;
      a_sh   <= a_sh >> 1;
      res_sh <= res_next[W:1];
      if (last_bit) begin
        cnt     <= '0;
        out_b   <= res_next[W-1:0];
        out_err <= brw_next | diff_bit;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_recover.sv
// Directed self-checking bench for adder_operand_recover at W=2.
module tb_adder_operand_recover;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sum;
  logic [1:0] in_a;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_b;
  logic       out_err;

  int errors = 0;
  int checks = 0;

  adder_operand_recover #(.W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_a      (in_a),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one job in IDLE, then waits (bounded) for out_valid.
  // Returns the number of cycles from the acceptance edge to out_valid.
  task automatic run_job(input logic [2:0] s, input logic [1:0] a,
                         input logic c, output int lat);
    in_sum   = s;
    in_a     = a;
    in_cin   = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_hi: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_b !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_b: got %b expected 00", out_b); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_lo: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_job(3'b101, 2'b10, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", lat); end
    checks++; if (out_b !== 2'b10) begin errors++; $display("[TB] FAIL basic_b: got %b expected 10", out_b); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_done: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_back: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_errors();
    int lat;
    out_ready = 1'b1;
    // 0 - 0 - 1 is negative
    run_job(3'b000, 2'b00, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL neg_latency: got %0d expected 3", lat); end
    checks++; if (out_b !== 2'b11) begin errors++; $display("[TB] FAIL neg_b: got %b expected 11", out_b); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL neg_err: got %b expected 1", out_err); end
    @(posedge clk); #1;
    // 7 - 0 - 0 = 7 does not fit in 2 bits
    run_job(3'b111, 2'b00, 1'b0, lat);
    checks++; if (out_b !== 2'b11) begin errors++; $display("[TB] FAIL ovf_b: got %b expected 11", out_b); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err: got %b expected 1", out_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    int lat;
    out_ready = 1'b1;
    // diff = 3 = 2^W - 1: largest legal value
    run_job(3'b011, 2'b00, 1'b0, lat);
    checks++; if (out_b !== 2'b11) begin errors++; $display("[TB] FAIL max_b: got %b expected 11", out_b); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL max_err: got %b expected 0", out_err); end
    @(posedge clk); #1;
    // diff = 4 = 2^W: error with zero low bits
    run_job(3'b100, 2'b00, 1'b0, lat);
    checks++; if (out_b !== 2'b00) begin errors++; $display("[TB] FAIL pow_b: got %b expected 00", out_b); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL pow_err: got %b expected 1", out_err); end
    @(posedge clk); #1;
    // 7 - 3 - 0 = 4, reached with a nonzero a
    run_job(3'b111, 2'b11, 1'b0, lat);
    checks++; if (out_b !== 2'b00) begin errors++; $display("[TB] FAIL pow2_b: got %b expected 00", out_b); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL pow2_err: got %b expected 1", out_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    // 4 - 1 - 0 = 3
    run_job(3'b100, 2'b01, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 3", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_sum   = 3'b010;
      in_a     = 2'b00;
      in_cin   = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_b !== 2'b11) begin errors++; $display("[TB] FAIL bp_b[%0d]: got %b expected 11", i, out_b); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL bp_err[%0d]: got %b expected 0", i, out_err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    in_sum   = 3'b101;
    in_a     = 2'b10;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_b !== 2'b00) begin errors++; $display("[TB] FAIL rmid_b: got %b expected 00", out_b); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_err: got %b expected 0", out_err); end
    // 5 - 3 - 0 = 2
    run_job(3'b101, 2'b11, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rmid_next_latency: got %0d expected 3", lat); end
    checks++; if (out_b !== 2'b10) begin errors++; $display("[TB] FAIL rmid_next_b: got %b expected 10", out_b); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_next_err: got %b expected 0", out_err); end
    @(posedge clk); #1;
  endtask

  // All (a, b, cin) with in_valid held high; inputs are scrambled after
  // each acceptance so any late sampling shows up as a wrong result.
  task automatic test_back_to_back();
    int lat;
    logic [2:0] sum_v;
    logic [1:0] a_v;
    logic [1:0] b_v;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          a_v   = 2'(a);
          b_v   = 2'(b);
          sum_v = 3'(a + b + c);
          in_sum = sum_v;
          in_a   = a_v;
          in_cin = c[0];
          checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready a=%0d b=%0d cin=%0d: got %b expected 1", a, b, c, in_ready); end
          @(posedge clk); #1;
          in_sum = ~sum_v;
          in_a   = ~a_v;
          in_cin = ~c[0];
          lat = 0;
          while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL b2b_latency a=%0d b=%0d cin=%0d: got %0d expected 3", a, b, c, lat); end
          checks++; if (out_b !== b_v) begin errors++; $display("[TB] FAIL b2b_b a=%0d b=%0d cin=%0d: got %b expected %b", a, b, c, out_b, b_v); end
          checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err a=%0d b=%0d cin=%0d: got %b expected 0", a, b, c, out_err); end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_ready a=%0d b=%0d cin=%0d: got %b expected 0", a, b, c, in_ready); end
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_a      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
